// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the ping-pong frame buffer: default geometry and the
// read-side FSM encoding.
package frame_buffer_pkg;

    localparam int NDATA_DEF     = 128;
    localparam int WIDTH_DEF     = 8;
    localparam int NDATA_LOG_DEF = $clog2(NDATA_DEF);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/frame_buffer_bank_mem.sv
// Two-bank sample store: one synchronous write port and one combinational
// read port. Contents are never reset.
module frame_bank_mem
    import frame_buffer_pkg::*;
#(
    parameter int NDATA     = NDATA_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int NDATA_LOG = $clog2(NDATA)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic                 wbank_i,
    input  logic [NDATA_LOG-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rbank_i,
    input  logic [NDATA_LOG-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [2][NDATA];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/frame_buffer.sv
// Ping-pong frame buffer: the counter writes samples by index into one bank
// while the other bank streams out in index order over valid/ready.
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int NDATA = NDATA_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NDATA)-1:0]     idx,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_vld,
    output logic                         cnt_hold,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(NDATA)-1:0]     dout_idx,
    output logic                         dout_vld,
    input  logic                         dout_rdy,
    output logic                         dout_last
);

    localparam int NDATA_LOG = $clog2(NDATA);
    localparam logic [NDATA_LOG-1:0] LAST_IDX = NDATA_LOG'(NDATA - 1);

    logic [1:0]           full_q, full_d;
    logic                 wbank_q, wbank_d;
    logic                 rbank_q, rbank_d;
    logic [NDATA_LOG-1:0] rptr_q, rptr_d;
    rd_state_e            state_q, state_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic [NDATA_LOG-1:0] dout_idx_q, dout_idx_d;
    logic                 dout_last_q, dout_last_d;
    logic                 dout_vld_q, dout_vld_d;

    logic                 wr_en;
    logic                 reg_free;
    logic [WIDTH-1:0]     rd_data;

    // Output handshake: a word transfers on an edge where dout_vld & dout_rdy;
    // while dout_vld & !dout_rdy the registered word and its tags hold stable.
    assign reg_free = ~dout_vld_q | dout_rdy;
    assign wr_en    = din_vld & ~full_q[wbank_q];
    assign cnt_hold = full_q[0] & full_q[1];

    frame_bank_mem #(
        .NDATA     (NDATA),
        .WIDTH     (WIDTH),
        .NDATA_LOG (NDATA_LOG)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .wbank_i (wbank_q),
        .waddr_i (idx),
        .wdata_i (din),
        .rbank_i (rbank_q),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        full_d      = full_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        rptr_d      = rptr_q;
        state_d     = state_q;
        dout_d      = dout_q;
        dout_idx_d  = dout_idx_q;
        dout_last_d = dout_last_q;
        dout_vld_d  = dout_vld_q;

        if (wr_en && (idx == LAST_IDX)) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end

        if (reg_free) begin
            dout_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = ST_STREAM;
                    rptr_d  = '0;
                end
            end
            ST_STREAM: begin
                if (reg_free) begin
                    dout_d      = rd_data;
                    dout_idx_d  = rptr_q;
                    dout_last_d = (rptr_q == LAST_IDX);
                    dout_vld_d  = 1'b1;
                    // The last word is already in the register, so the bank can be
                    // handed back to the writer on this same edge.
                    if (rptr_q == LAST_IDX) begin
                        full_d[rbank_q] = 1'b0;
                        rbank_d         = ~rbank_q;
                        rptr_d          = '0;
                        state_d         = full_q[~rbank_q] ? ST_STREAM : ST_IDLE;
                    end else begin
                        rptr_d = rptr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            rptr_q      <= '0;
            state_q     <= ST_IDLE;
            dout_q      <= '0;
            dout_idx_q  <= '0;
            dout_last_q <= 1'b0;
            dout_vld_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            rptr_q      <= rptr_d;
            state_q     <= state_d;
            dout_q      <= dout_d;
            dout_idx_q  <= dout_idx_d;
            dout_last_q <= dout_last_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    assign dout      = dout_q;
    assign dout_idx  = dout_idx_q;
    assign dout_last = dout_last_q;
    assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with NDATA=4, WIDTH=8: fill, backpressure,
// both-banks-full, refill during drain, reset mid-stream and sparse indices.
module tb_frame_buffer;

    localparam int NDATA = 4;
    localparam int WIDTH = 8;
    localparam int NL    = $clog2(NDATA);

    logic             clk = 1'b0;
    logic             rst;
    logic [NL-1:0]    idx;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic             cnt_hold;
    logic [WIDTH-1:0] dout;
    logic [NL-1:0]    dout_idx;
    logic             dout_vld;
    logic             dout_rdy;
    logic             dout_last;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_buffer #(.NDATA(NDATA), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .din       (din),
        .din_vld   (din_vld),
        .cnt_hold  (cnt_hold),
        .dout      (dout),
        .dout_idx  (dout_idx),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input logic [WIDTH-1:0] d);
        idx     = NL'(i);
        din     = d;
        din_vld = 1'b1;
    endtask

    task automatic wr(input int i, input logic [WIDTH-1:0] d);
        set_wr(i, d);
        step();
        din_vld = 1'b0;
    endtask

    task automatic wr_frame(input logic [WIDTH-1:0] base);
        for (int i = 0; i < NDATA; i++) begin
            wr(i, base + WIDTH'(i));
        end
    endtask

    // Check the word currently presented, then advance one clock.
    task automatic expect_word(input string tag, input logic [WIDTH-1:0] d,
                               input int i, input logic last);
        check({tag, "_vld"}, 32'(dout_vld), 32'd1);
        check({tag, "_dat"}, 32'(dout), 32'(d));
        check({tag, "_idx"}, 32'(dout_idx), 32'(i));
        check({tag, "_last"}, 32'(dout_last), 32'(last));
        step();
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!dout_vld && n < 20) begin
            step();
            n++;
        end
        check({tag, "_wait"}, 32'(dout_vld), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        idx      = '0;
        din      = '0;
        din_vld  = 1'b0;
        dout_rdy = 1'b0;
        step();
        step();
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_idx", 32'(dout_idx), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_hold", 32'(cnt_hold), 32'd0);
        rst = 1'b0;

        // Fill: latency of two edges after the closing write.
        dout_rdy = 1'b1;
        wr_frame(8'h10);
        check("fill_lat0", 32'(dout_vld), 32'd0);
        step();
        check("fill_lat1", 32'(dout_vld), 32'd0);
        step();
        expect_word("fill0", 8'h10, 0, 1'b0);
        expect_word("fill1", 8'h11, 1, 1'b0);
        expect_word("fill2", 8'h12, 2, 1'b0);
        expect_word("fill3", 8'h13, 3, 1'b1);
        check("fill_end", 32'(dout_vld), 32'd0);

        // Backpressure: word 1 held for three stalled edges.
        wr_frame(8'h20);
        wait_vld("bp");
        expect_word("bp0", 8'h20, 0, 1'b0);
        dout_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_dat", 32'(dout), 32'h21);
            check("bp_hold_idx", 32'(dout_idx), 32'd1);
            check("bp_hold_vld", 32'(dout_vld), 32'd1);
        end
        dout_rdy = 1'b1;
        expect_word("bp1", 8'h21, 1, 1'b0);
        expect_word("bp2", 8'h22, 2, 1'b0);
        expect_word("bp3", 8'h23, 3, 1'b1);
        check("bp_end", 32'(dout_vld), 32'd0);

        // Both full, ignored write, drain with refill of bank 0 during B.
        dout_rdy = 1'b0;
        wr_frame(8'hA0);
        check("a_only_hold", 32'(cnt_hold), 32'd0);
        wr_frame(8'hB0);
        check("both_hold", 32'(cnt_hold), 32'd1);
        wr(1, 8'hFF);
        check("ign_hold", 32'(cnt_hold), 32'd1);
        dout_rdy = 1'b1;
        expect_word("a0", 8'hA0, 0, 1'b0);
        check("hold_a1", 32'(cnt_hold), 32'd1);
        expect_word("a1", 8'hA1, 1, 1'b0);
        check("hold_a2", 32'(cnt_hold), 32'd1);
        expect_word("a2", 8'hA2, 2, 1'b0);
        check("hold_drop", 32'(cnt_hold), 32'd0);
        set_wr(0, 8'hC0);
        expect_word("a3", 8'hA3, 3, 1'b1);
        set_wr(1, 8'hC1);
        expect_word("b0", 8'hB0, 0, 1'b0);
        set_wr(2, 8'hC2);
        expect_word("b1", 8'hB1, 1, 1'b0);
        set_wr(3, 8'hC3);
        expect_word("b2", 8'hB2, 2, 1'b0);
        din_vld = 1'b0;
        check("simul_hold", 32'(cnt_hold), 32'd0);
        expect_word("b3", 8'hB3, 3, 1'b1);
        wait_vld("c");
        expect_word("c0", 8'hC0, 0, 1'b0);
        expect_word("c1", 8'hC1, 1, 1'b0);
        expect_word("c2", 8'hC2, 2, 1'b0);
        expect_word("c3", 8'hC3, 3, 1'b1);
        check("c_end", 32'(dout_vld), 32'd0);

        // Reset while word 2 of frame D is presented.
        wr_frame(8'h40);
        wait_vld("d");
        expect_word("d0", 8'h40, 0, 1'b0);
        expect_word("d1", 8'h41, 1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_vld", 32'(dout_vld), 32'd0);
        check("mrst_hold", 32'(cnt_hold), 32'd0);
        check("mrst_dout", 32'(dout), 32'd0);
        wr_frame(8'h50);
        wait_vld("e");
        expect_word("e0", 8'h50, 0, 1'b0);
        expect_word("e1", 8'h51, 1, 1'b0);
        expect_word("e2", 8'h52, 2, 1'b0);
        expect_word("e3", 8'h53, 3, 1'b1);

        // Sparse indices into bank 1: idx 1 keeps D1 from before the reset.
        wr(0, 8'h60);
        step();
        wr(2, 8'h62);
        repeat (3) step();
        check("sparse_open", 32'(dout_vld), 32'd0);
        wr(3, 8'h63);
        wait_vld("sp");
        expect_word("sp0", 8'h60, 0, 1'b0);
        expect_word("sp1", 8'h41, 1, 1'b0);
        expect_word("sp2", 8'h62, 2, 1'b0);
        expect_word("sp3", 8'h63, 3, 1'b1);
        check("sp_end", 32'(dout_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
